fir_feeder: RTL and testbench
=============================

# fir_feeder

Upstream pacing stage for the 16-tap FIR filter. Accepts 16-bit signed samples from a producer over a valid/ready handshake, buffers them in a small FIFO, and releases them to the FIR one at a time. Each release is a single-cycle `input_ready` pulse with the sample held stable on `fir_in`. The next sample is not issued until the FIR reports completion via `output_ready` plus a guard gap, so the FIR never receives a sample while it is processing.

## Interface
- `DEPTH`, 8: FIFO depth in samples; power of two, 2..64.
- `GAP_CYCLES`, 2: idle cycles inserted after FIR completion before the next issue; 0..15.
- `TIMEOUT`, 64: maximum cycles to wait for FIR completion; must be greater than 20.
- `ck`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  16  signed producer sample.
- `s_valid`  in  1  producer has a sample on `s_data`.
- `s_ready`  out  1  FIFO can accept a sample this cycle.
- `fir_in`  out  16  signed sample to the FIR `in`.
- `fir_input_ready`  out  1  one-cycle issue pulse to the FIR `input_ready`.
- `fir_output_ready`  in  1  FIR `output_ready`, high for one cycle when the result is saved.
- `busy`  out  1  a sample is in flight in the FIR (state is not IDLE).
- `fifo_count`  out  $clog2(DEPTH)+1  number of samples buffered.
- `timeout_err`  out  1  sticky; set when a FIR completion is missed.

## Operation
- **Push:** a push occurs on an edge where `s_valid && s_ready`. `s_ready = !rst && (fifo_count < DEPTH)`. It is combinational and does not look ahead at a same-cycle pop, so no push is accepted when full, even if a pop occurs that cycle.
- **Pop:** occurs only on an issue edge. A push and pop on the same edge leave `fifo_count` unchanged and keep FIFO order.
- **FSM states:** IDLE, WAIT_DONE, GAP.
- **IDLE:** if `fifo_count != 0`, then on the edge:
  - `fir_in` <= head;
  - pop;
  - `fir_input_ready` <= 1;
  - timeout counter <= 0;
  - go to WAIT_DONE.
- **WAIT_DONE:**
  - `fir_input_ready` <= 0 on the first edge.
  - On `fir_output_ready`, go to GAP (or IDLE if `GAP_CYCLES` = 0).
  - If the counter reaches `TIMEOUT-1` without `fir_output_ready`, set `timeout_err` and go to GAP.
  - `fir_output_ready` is ignored in IDLE and GAP.
- **GAP:** count `GAP_CYCLES` cycles, then go to IDLE.
- **Hold:** `fir_in` holds its value until the next issue. The FIR samples it one cycle after the pulse.
- **Clearing `timeout_err`:** only `rst` clears it.
- **Arithmetic:** samples are passed unmodified, with no width change. Pointers wrap modulo `DEPTH`.

## Timing
- **Reset values:** state IDLE, `fir_in` 0, `fir_input_ready` 0, `busy` 0, `fifo_count` 0, `timeout_err` 0, pointers 0, `s_ready` 0 while `rst` is high.
- **Empty-FIFO latency:** a sample pushed on edge k into an empty FIFO with the FSM in IDLE drives `fir_input_ready` high during the cycle after edge k+1, i.e. 2-cycle latency.
- **Pulse width:** `fir_input_ready` is exactly one cycle wide and is never asserted outside the IDLE→WAIT_DONE transition.
- **Issue spacing:** minimum spacing between issues is (cycles to FIR `output_ready`) + `GAP_CYCLES` + 1. With the 16-tap FIR this is ≥ 21 cycles.
- **Reset mid-operation:** reset in any state empties the FIFO, drops the in-flight sample and drops `fir_input_ready` immediately (asynchronous). The FIR is reset by the same `rst`.
- **Boundary:** `fir_output_ready` arriving on the same edge as the timeout takes priority. In that case `timeout_err` is not set.

## Structure
- **Package `fir_pkg`:**
  - `sample_t` (`logic signed [15:0]`), shared with the FIR;
  - `feeder_state_t` enum {IDLE, WAIT_DONE, GAP};
  - `localparam FIR_TAPS = 16`.
- **Sub-module `sample_fifo`:** parameterised on `DEPTH`, with push/pop/head/count. It is synchronous, with a registered memory and async-reset pointers. `fir_feeder` instantiates it plus the FSM and its counters.

## Test plan
- **Single sample:** push 16'sh1234 with the FSM idle → `fir_input_ready` pulses one cycle, 2 cycles later, with `fir_in` = 16'sh1234. After the FIR model returns `output_ready` at +20 cycles, `busy` falls 2 cycles later.
- **Burst:** push 10 samples (1..10) back-to-back → `s_ready` drops when `fifo_count` = 8. Samples reach `fir_in` in order 1..10, with issue spacing ≥ 21 cycles.
- **Full-FIFO push/pop:** with FIFO full and `s_valid` held on an issue edge → no push, `fifo_count` goes 8→7, and a push is accepted next cycle.
- **Timeout:** FIR model never asserts `output_ready` → `timeout_err` rises 64 cycles after the issue pulse. The next sample issues after the gap, and `timeout_err` stays 1.
- **Reset mid-operation:** assert `rst` during WAIT_DONE with 3 samples buffered → all outputs return to reset values within the same cycle. After release, `fifo_count` = 0 and there is no spurious pulse.
- **Completion/timeout collision:** `output_ready` arrives on the timeout edge → `timeout_err` stays 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR front end.
package fir_pkg;

    // Sample format shared by the feeder and the 16-tap FIR.
    typedef logic signed [15:0] sample_t;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } feeder_state_t;

    localparam int FIR_TAPS = 16;

endpackage : fir_pkg

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO: registered storage, async-reset pointers and
// occupancy count. Push is refused when full and pop when empty.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic                   push_i,
    input  sample_t                push_data_i,
    input  logic                   pop_i,
    output sample_t                head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    sample_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && (count_q < FULL_COUNT);
    assign do_pop  = pop_i && (count_q != '0);

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state, cleared asynchronously.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge ck) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : sample_fifo

// File: rtl/fir_feeder.sv
// Paces buffered producer samples into the FIR: one single-cycle issue
// pulse per sample, then wait for FIR completion (or a timeout) and a
// guard gap before the next issue.
module fir_feeder
    import fir_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                   ck,
    input  logic                   rst,
    input  sample_t                s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output sample_t                fir_in,
    output logic                   fir_input_ready,
    input  logic                   fir_output_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   timeout_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    // With no guard gap, GAP is only reached on a timeout and lasts one cycle.
    localparam logic [3:0]    GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    // Reject parameter sets the sequencer cannot honour.
    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fir_feeder: DEPTH must be a power of two in 2..64");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_bad_gap
        $error("fir_feeder: GAP_CYCLES must be in 0..15");
    end
    if (TIMEOUT <= FIR_TAPS + 4) begin : g_bad_timeout
        $error("fir_feeder: TIMEOUT must exceed the FIR processing time");
    end

    feeder_state_t   state_q;
    sample_t         fir_in_q;
    logic            fir_input_ready_q;
    logic            busy_q;
    logic            timeout_err_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [3:0]      gap_cnt_q;

    sample_t         fifo_head;
    logic [CW-1:0]   fifo_cnt;
    logic            push;
    logic            issue;

    // Ready does not anticipate a same-cycle pop, so a full FIFO never accepts.
    assign s_ready = !rst && (fifo_cnt < FULL_COUNT);
    assign push    = s_valid && s_ready;
    assign issue   = (state_q == IDLE) && (fifo_cnt != '0);

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck          (ck),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (s_data),
        .pop_i       (issue),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt)
    );

    // Issue sequencer: issue pulse, completion/timeout wait, guard gap.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            fir_in_q          <= '0;
            fir_input_ready_q <= 1'b0;
            busy_q            <= 1'b0;
            timeout_err_q     <= 1'b0;
            tmo_cnt_q         <= '0;
            gap_cnt_q         <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    fir_input_ready_q <= 1'b0;
                    if (issue) begin
                        fir_in_q          <= fifo_head;
                        fir_input_ready_q <= 1'b1;
                        tmo_cnt_q         <= '0;
                        busy_q            <= 1'b1;
                        state_q           <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    fir_input_ready_q <= 1'b0;
                    // A completion on the timeout edge wins over the timeout.
                    if (fir_output_ready) begin
                        gap_cnt_q <= 4'd0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        timeout_err_q <= 1'b1;
                        gap_cnt_q     <= 4'd0;
                        state_q       <= GAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                GAP: begin
                    fir_input_ready_q <= 1'b0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q           <= IDLE;
                    fir_input_ready_q <= 1'b0;
                    busy_q            <= 1'b0;
                end
            endcase
        end
    end

    assign fir_in          = fir_in_q;
    assign fir_input_ready = fir_input_ready_q;
    assign busy            = busy_q;
    assign fifo_count      = fifo_cnt;
    assign timeout_err     = timeout_err_q;

endmodule : fir_feeder

// File: tb/tb_fir_feeder.sv
// Scoreboard bench for fir_feeder with a simple FIR completion model.
module tb_fir_feeder;
    import fir_pkg::*;

    logic        ck = 1'b0;
    logic        rst;
    sample_t     s_data;
    logic        s_valid;
    logic        s_ready;
    sample_t     fir_in;
    logic        fir_input_ready;
    logic        fir_output_ready;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        timeout_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_issue = -1;
    bit          check_spacing = 1'b0;
    int          exp_spacing = 24;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic        prev_pulse = 1'b0;
    int          fir_lat = 20;
    bit          fir_en = 1'b1;
    int          fir_cd = 0;

    fir_feeder #(
        .DEPTH      (8),
        .GAP_CYCLES (2),
        .TIMEOUT    (64)
    ) dut (
        .ck               (ck),
        .rst              (rst),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .fir_in           (fir_in),
        .fir_input_ready  (fir_input_ready),
        .fir_output_ready (fir_output_ready),
        .busy             (busy),
        .fifo_count       (fifo_count),
        .timeout_err      (timeout_err)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired, required event did not occur", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] v);
        int t = 0;
        s_data  = v;
        s_valid = 1'b1;
        while (!s_ready && t < 200) begin
            @(negedge ck);
            t++;
        end
        if (!s_ready) fail_bound("push_wait");
        else exp_q.push_back(v);
        @(negedge ck);
        s_valid = 1'b0;
    endtask

    task automatic wait_issue(input string name, input int lim);
        int t = 0;
        while (!fir_input_ready && t < lim) begin
            @(negedge ck);
            t++;
        end
        if (!fir_input_ready) fail_bound(name);
    endtask

    // FIR model: output_ready for one cycle, fir_lat negedges after the pulse.
    initial begin
        fir_output_ready = 1'b0;
        forever begin
            @(negedge ck);
            fir_output_ready = 1'b0;
            if (rst) begin
                fir_cd = 0;
            end else begin
                if (fir_cd > 0) begin
                    fir_cd--;
                    if (fir_cd == 0) fir_output_ready = 1'b1;
                end
                if (fir_input_ready && fir_en) fir_cd = fir_lat;
            end
        end
    end

    // Monitor: every issue pulse is checked against the scoreboard.
    always @(negedge ck) begin
        if (!rst && fir_input_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got pulse with fir_in=%0h, required no issue", fir_in);
            end else begin
                exp_v = exp_q.pop_front();
                check("fir_in_order", fir_in, exp_v);
            end
            check("pulse_isolated", {15'd0, prev_pulse}, 16'd0);
            if (check_spacing && last_issue >= 0)
                check("issue_spacing", 16'(cyc - last_issue), 16'(exp_spacing));
            last_issue = cyc;
        end
        prev_pulse = fir_input_ready && !rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'sh0000;
        tick(2);
        check("rst_s_ready", {15'd0, s_ready}, 16'd0);
        check("rst_count", 16'(fifo_count), 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_pulse", {15'd0, fir_input_ready}, 16'd0);
        check("rst_fir_in", fir_in, 16'h0000);
        check("rst_tmo", {15'd0, timeout_err}, 16'd0);
        rst = 1'b0;
        tick(2);

        // Single sample: 2-cycle latency, 1-cycle pulse, busy falls after gap.
        fir_lat = 20;
        s_data  = 16'sh1234;
        s_valid = 1'b1;
        check("s_ready_idle", {15'd0, s_ready}, 16'd1);
        exp_q.push_back(16'h1234);
        tick(1);
        s_valid = 1'b0;
        check("count_after_push", 16'(fifo_count), 16'd1);
        check("no_pulse_yet", {15'd0, fir_input_ready}, 16'd0);
        tick(1);
        check("pulse_latency", {15'd0, fir_input_ready}, 16'd1);
        check("busy_on_issue", {15'd0, busy}, 16'd1);
        check("count_after_pop", 16'(fifo_count), 16'd0);
        tick(1);
        check("pulse_width", {15'd0, fir_input_ready}, 16'd0);
        tick(21);
        check("busy_in_gap", {15'd0, busy}, 16'd1);
        tick(1);
        check("busy_fall", {15'd0, busy}, 16'd0);
        tick(3);

        // Burst of 10: fills FIFO, full-FIFO push/pop edge, ordered spaced issues.
        last_issue    = -1;
        check_spacing = 1'b1;
        for (int i = 1; i <= 9; i++) push(16'(i));
        check("full_count", 16'(fifo_count), 16'd8);
        check("full_s_ready", {15'd0, s_ready}, 16'd0);
        s_data  = 16'sh000A;
        s_valid = 1'b1;
        wait_issue("burst_second_issue", 100);
        check("full_pop_no_push", 16'(fifo_count), 16'd7);
        check("ready_after_pop", {15'd0, s_ready}, 16'd1);
        exp_q.push_back(16'h000A);
        tick(1);
        s_valid = 1'b0;
        check("push_after_pop", 16'(fifo_count), 16'd8);
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            tick(1);
            t++;
        end
        if (exp_q.size() != 0 || busy) fail_bound("burst_drain");
        check_spacing = 1'b0;
        tick(2);

        // Completion exactly on the timeout edge must not flag an error.
        fir_lat = 63;
        push(16'h8000);
        wait_issue("collision_issue", 10);
        tick(63);
        check("collision_busy", {15'd0, busy}, 16'd1);
        check("collision_pre", {15'd0, timeout_err}, 16'd0);
        t = 0;
        while (busy && t < 20) begin
            tick(1);
            t++;
        end
        if (busy) fail_bound("collision_done");
        check("collision_no_err", {15'd0, timeout_err}, 16'd0);
        tick(2);

        // Reset while waiting with three samples buffered.
        fir_lat = 20;
        push(16'h0111);
        push(16'h0222);
        push(16'h0333);
        push(16'h0444);
        tick(2);
        check("pre_rst_count", 16'(fifo_count), 16'd3);
        check("pre_rst_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_count", 16'(fifo_count), 16'd0);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_pulse", {15'd0, fir_input_ready}, 16'd0);
        check("mid_rst_s_ready", {15'd0, s_ready}, 16'd0);
        check("mid_rst_fir_in", fir_in, 16'h0000);
        tick(3);
        rst = 1'b0;
        tick(1);
        check("post_rst_count", 16'(fifo_count), 16'd0);
        check("post_rst_s_ready", {15'd0, s_ready}, 16'd1);
        tick(30);
        check("post_rst_idle", {15'd0, busy}, 16'd0);

        // Timeout: FIR never completes; error is sticky, next sample follows the gap.
        fir_en = 1'b0;
        push(16'h0ABC);
        push(16'hF00D);
        wait_issue("timeout_issue", 10);
        tick(63);
        check("timeout_not_early", {15'd0, timeout_err}, 16'd0);
        tick(1);
        check("timeout_rise", {15'd0, timeout_err}, 16'd1);
        check("timeout_busy", {15'd0, busy}, 16'd1);
        tick(2);
        check("timeout_gap_quiet", {15'd0, fir_input_ready}, 16'd0);
        tick(1);
        check("timeout_next_issue", {15'd0, fir_input_ready}, 16'd1);
        check("timeout_sticky", {15'd0, timeout_err}, 16'd1);
        t = 0;
        while (busy && t < 100) begin
            tick(1);
            t++;
        end
        if (busy) fail_bound("timeout_done");
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        check("timeout_still_set", {15'd0, timeout_err}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fir_feeder
